layered_objects_mux: RTL and testbench

- Parametrised, pipelined priority mux for the VGA path. Generalises the fixed monkey/numbers/operand/ropes mux to LAYERS generic layers.
- Each layer has a runtime enable, a transparent colour key and per-layer blinking.
- Per-pixel and per-frame collision reporting feeds game logic.
- Sits between the object drawers and the VGA controller. Output is RGBOut.

---
 rtl/layered_objects_mux.sv | 96 +++++++++
 tb/tb_layered_objects_mux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/layered_objects_mux.sv
// rtl/layered_objects_mux.sv - two-stage priority mux over LAYERS object layers
// with colour-key transparency, per-layer blink, and per-pixel/per-frame collision flags.
module layered_objects_mux #(
  parameter int                 LAYERS       = 8,
  parameter int                 COLOR_W      = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT  = {COLOR_W{1'b1}},
  parameter int                 BLINK_PERIOD = 16,
  parameter int                 CNT_W        = 5
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [LAYERS-1:0]               layersDR,
  input  logic [LAYERS-1:0][COLOR_W-1:0]  layersRGB,
  input  logic [COLOR_W-1:0]              backGroundRGB,
  input  logic [LAYERS-1:0]               layerEnable,
  input  logic [LAYERS-1:0]               layerBlink,
  input  logic                            startOfFrame,
  output logic [COLOR_W-1:0]              RGBOut,
  output logic                            pixelCollision,
  output logic [LAYERS-1:0]               frameCollisions,
  output logic                            blinkPhase
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LAYERS-1:0] EFF_ONE  = LAYERS'(1);

  logic [LAYERS-1:0]              w_eff;
  logic                           w_multi;
  logic [COLOR_W-1:0]             w_sel;
  logic [LAYERS-1:0]              w_hit;

  logic [LAYERS-1:0]              r_eff;
  logic [LAYERS-1:0][COLOR_W-1:0] r_rgb;
  logic [COLOR_W-1:0]             r_bg;
  logic                           r_multi;
  logic [LAYERS-1:0]              r_acc;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_blink;

  always_comb begin
    w_eff = '0;
    for (int i = 0; i < LAYERS; i++) begin
      w_eff[i] = layersDR[i] & layerEnable[i] & ~(layerBlink[i] & r_blink)
                 & (layersRGB[i] != TRANSPARENT);
    end
    // clearing the lowest set bit leaves something only if two or more bits were set
    w_multi = (w_eff & (w_eff - EFF_ONE)) != '0;
  end

  always_comb begin
    w_sel = r_bg;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (r_eff[i]) w_sel = r_rgb[i];
    end
    w_hit = r_multi ? r_eff : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_eff           <= '0;
      r_rgb           <= '0;
      r_bg            <= '0;
      r_multi         <= 1'b0;
      r_acc           <= '0;
      r_cnt           <= '0;
      r_blink         <= 1'b0;
      RGBOut          <= '0;
      pixelCollision  <= 1'b0;
      frameCollisions <= '0;
    end else begin
      r_eff          <= w_eff;
      r_rgb          <= layersRGB;
      r_bg           <= backGroundRGB;
      r_multi        <= w_multi;
      RGBOut         <= w_sel;
      pixelCollision <= r_multi;
      // the stage-1 pixel is the last of the closing frame, so it is merged into the report
      if (startOfFrame) begin
        frameCollisions <= r_acc | w_hit;
        r_acc           <= '0;
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else begin
        r_acc <= r_acc | w_hit;
      end
    end
  end

  assign blinkPhase = r_blink;

endmodule

// File: tb/tb_layered_objects_mux.sv
// tb/tb_layered_objects_mux.sv - self-checking bench for layered_objects_mux
// directed scenarios plus randomized traffic against a frame-level reference model.
module tb_layered_objects_mux;

  localparam int L  = 8;
  localparam int BP = 2;

  logic              clk = 1'b0;
  logic              resetN;
  logic [L-1:0]      dr;
  logic [L-1:0][7:0] rgb;
  logic [7:0]        bg;
  logic [L-1:0]      en;
  logic [L-1:0]      blink;
  logic              sof;
  logic [7:0]        rgb_out;
  logic              pix_coll;
  logic [L-1:0]      frame_coll;
  logic              phase;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int           m_frames;
  logic [L-1:0] m_acc;
  logic [L-1:0] m_fc;
  logic [7:0]   m_rgb;
  logic         m_coll;
  logic [7:0]   s1_rgb;
  logic         s1_coll;
  logic         m_phase;

  layered_objects_mux #(
    .LAYERS(L), .COLOR_W(8), .TRANSPARENT(8'hFF), .BLINK_PERIOD(BP), .CNT_W(5)
  ) dut (
    .clk(clk), .resetN(resetN), .layersDR(dr), .layersRGB(rgb),
    .backGroundRGB(bg), .layerEnable(en), .layerBlink(blink),
    .startOfFrame(sof), .RGBOut(rgb_out), .pixelCollision(pix_coll),
    .frameCollisions(frame_coll), .blinkPhase(phase)
  );

  always #5 clk = ~clk;

  // one clock: the model judges the pixel presented now, then the DUT edge happens
  task automatic tick();
    logic [L-1:0] peff;
    logic [7:0]   prgb;
    logic         pcoll;
    int           n;
    bit           ph;
    ph   = ((m_frames / BP) % 2) == 1;
    peff = '0;
    n    = 0;
    for (int i = 0; i < L; i++) begin
      if (dr[i] && en[i] && !(blink[i] && ph) && rgb[i] != 8'hFF) begin
        peff[i] = 1'b1;
        n++;
      end
    end
    prgb = bg;
    for (int i = 0; i < L; i++) begin
      if (peff[i]) begin
        prgb = rgb[i];
        break;
      end
    end
    pcoll = (n >= 2);
    @(posedge clk);
    if (!resetN) begin
      m_frames = 0; m_acc = '0; m_fc = '0; m_rgb = '0; m_coll = 1'b0;
      s1_rgb = '0; s1_coll = 1'b0;
    end else begin
      m_rgb  = s1_rgb;
      m_coll = s1_coll;
      if (sof) begin
        m_fc  = m_acc;
        m_acc = pcoll ? peff : '0;
        m_frames++;
      end else if (pcoll) begin
        m_acc |= peff;
      end
      s1_rgb  = prgb;
      s1_coll = pcoll;
    end
    m_phase = ((m_frames / BP) % 2) == 1;
    #1;
  endtask

  task automatic idle_inputs();
    dr = '0; rgb = '0; bg = 8'h00; en = '1; blink = '0; sof = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; idle_inputs(); bg = 8'h25;
    tick(); tick();
    n_checks++; if (rgb_out !== 8'h00) begin n_fail++; $display("FAIL reset_rgb: got %h expected 00", rgb_out); end
    n_checks++; if ({pix_coll, phase, frame_coll} !== '0) begin n_fail++;
      $display("FAIL reset_flags: got coll=%b phase=%b fc=%h expected 0", pix_coll, phase, frame_coll); end
    resetN = 1'b1;
    tick();
    n_checks++; if (rgb_out !== 8'h00) begin n_fail++; $display("FAIL release_edge1: got %h expected 00", rgb_out); end
    tick();
    n_checks++; if (rgb_out !== 8'h25) begin n_fail++; $display("FAIL background: got %h expected 25", rgb_out); end
    n_checks++; if ({pix_coll, phase, frame_coll} !== '0) begin n_fail++;
      $display("FAIL bg_flags: got coll=%b phase=%b fc=%h expected 0", pix_coll, phase, frame_coll); end
  endtask

  task automatic test_priority();
    rgb[3] = 8'h1C; rgb[5] = 8'hE0; dr = 8'b0010_1000;
    tick(); tick();
    n_checks++; if (rgb_out !== 8'h1C) begin n_fail++; $display("FAIL prio_rgb: got %h expected 1c", rgb_out); end
    n_checks++; if (pix_coll !== 1'b1) begin n_fail++; $display("FAIL prio_coll: got %b expected 1", pix_coll); end
    en[3] = 1'b0;
    tick(); tick();
    n_checks++; if (rgb_out !== 8'hE0) begin n_fail++; $display("FAIL disable_rgb: got %h expected e0", rgb_out); end
    n_checks++; if (pix_coll !== 1'b0) begin n_fail++; $display("FAIL disable_coll: got %b expected 0", pix_coll); end
    en = '1; dr = '0;
  endtask

  task automatic test_transparency();
    sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (frame_coll !== 8'h28) begin n_fail++; $display("FAIL prio_frame: got %h expected 28", frame_coll); end
    rgb[0] = 8'hFF; rgb[2] = 8'h03; dr = 8'b0000_0101;
    tick(); tick();
    n_checks++; if (rgb_out !== 8'h03) begin n_fail++; $display("FAIL transp_rgb: got %h expected 03", rgb_out); end
    n_checks++; if (pix_coll !== 1'b0) begin n_fail++; $display("FAIL transp_coll: got %b expected 0", pix_coll); end
    dr = '0; sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (frame_coll !== 8'h00) begin n_fail++; $display("FAIL transp_acc: got %h expected 00", frame_coll); end
  endtask

  task automatic test_frame_collisions();
    rgb = '0; rgb[1] = 8'h11; rgb[4] = 8'h44; dr = 8'b0001_0010;
    repeat (3) tick();
    dr = '0; tick();
    sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (frame_coll !== 8'b0001_0010) begin n_fail++; $display("FAIL frame_1_4: got %b expected 00010010", frame_coll); end
    repeat (3) tick();
    n_checks++; if (frame_coll !== 8'b0001_0010) begin n_fail++; $display("FAIL frame_hold: got %b expected 00010010", frame_coll); end
    sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (frame_coll !== 8'h00) begin n_fail++; $display("FAIL frame_clean: got %h expected 00", frame_coll); end
    rgb[0] = 8'h01; rgb[7] = 8'h07; dr = 8'b1000_0001; tick();
    dr = '0; sof = 1'b1; tick();
    n_checks++; if (frame_coll !== 8'h81) begin n_fail++; $display("FAIL frame_inflight: got %h expected 81", frame_coll); end
    rgb[2] = 8'h02; rgb[6] = 8'h06; dr = 8'b0100_0100; tick();
    n_checks++; if (frame_coll !== 8'h00) begin n_fail++; $display("FAIL frame_b2b: got %h expected 00", frame_coll); end
    dr = '0; sof = 1'b0; tick();
    sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (frame_coll !== 8'h44) begin n_fail++; $display("FAIL frame_first_pixel: got %h expected 44", frame_coll); end
  endtask

  task automatic test_blink();
    int toggles;
    logic prev;
    idle_inputs(); blink[0] = 1'b1; dr[0] = 1'b1; rgb[0] = 8'h10;
    toggles = 0;
    prev = phase;
    for (int f = 0; f < 8; f++) begin
      sof = 1'b1; tick(); sof = 1'b0;
      if (phase !== prev) toggles++;
      prev = phase;
      n_checks++; if (phase !== m_phase) begin n_fail++; $display("FAIL blink_phase: got %b expected %b", phase, m_phase); end
      repeat (3) tick();
      n_checks++; if (rgb_out !== (m_phase ? 8'h00 : 8'h10)) begin n_fail++;
        $display("FAIL blink_rgb: got %h expected %h", rgb_out, m_phase ? 8'h00 : 8'h10); end
    end
    n_checks++; if (toggles != 4) begin n_fail++; $display("FAIL blink_toggles: got %0d expected 4", toggles); end
  endtask

  task automatic test_reset_mid_frame();
    idle_inputs();
    for (int k = 0; k < 4 && !m_phase; k++) begin sof = 1'b1; tick(); end
    sof = 1'b0;
    n_checks++; if (phase !== 1'b1) begin n_fail++; $display("FAIL rst_setup_phase: got %b expected 1", phase); end
    rgb[1] = 8'h21; rgb[2] = 8'h22; dr = 8'b0000_0110; tick();
    resetN = 1'b0; tick();
    n_checks++; if ({rgb_out, pix_coll, frame_coll, phase} !== '0) begin n_fail++;
      $display("FAIL rst_mid: got rgb=%h coll=%b fc=%h phase=%b expected all 0", rgb_out, pix_coll, frame_coll, phase); end
    resetN = 1'b1; dr = '0; tick(); tick();
    sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (frame_coll !== 8'h00) begin n_fail++; $display("FAIL rst_first_frame: got %h expected 00", frame_coll); end
    n_checks++; if (phase !== 1'b0) begin n_fail++; $display("FAIL rst_counter_1: got %b expected 0", phase); end
    sof = 1'b1; tick(); sof = 1'b0;
    n_checks++; if (phase !== 1'b1) begin n_fail++; $display("FAIL rst_counter_2: got %b expected 1", phase); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      resetN = ($urandom_range(0, 199) != 0);
      sof    = ($urandom_range(0, 9) == 0);
      dr     = L'($urandom);
      en     = L'($urandom) | L'($urandom);
      blink  = L'($urandom);
      bg     = 8'($urandom);
      for (int i = 0; i < L; i++) rgb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      tick();
      n_checks++; if (rgb_out !== m_rgb) begin n_fail++; $display("FAIL rand_rgb c=%0d: got %h expected %h", c, rgb_out, m_rgb); end
      n_checks++; if (pix_coll !== m_coll) begin n_fail++; $display("FAIL rand_coll c=%0d: got %b expected %b", c, pix_coll, m_coll); end
      n_checks++; if (frame_coll !== m_fc) begin n_fail++; $display("FAIL rand_frame c=%0d: got %h expected %h", c, frame_coll, m_fc); end
      n_checks++; if (phase !== m_phase) begin n_fail++; $display("FAIL rand_phase c=%0d: got %b expected %b", c, phase, m_phase); end
    end
    resetN = 1'b1;
  endtask

  initial begin
    m_frames = 0; m_acc = '0; m_fc = '0; m_rgb = '0; m_coll = 1'b0;
    s1_rgb = '0; s1_coll = 1'b0; m_phase = 1'b0;
    resetN = 1'b0;
    idle_inputs();
    test_reset();
    test_priority();
    test_transparency();
    test_frame_collisions();
    test_blink();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
